// File: rtl/pic_multimode.sv
// 8259-style interrupt controller: edge/level trigger, auto-EOI, rotating and
// specific priority, registered intr/irq toward the CPU.
module pic_multimode #(
  parameter int NUM_IRQ = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cs,
  input  logic               addr,
  input  logic [15:0]        data_m_data_in,
  output logic [15:0]        data_m_data_out,
  input  logic               data_m_wr_en,
  input  logic               data_m_access,
  output logic               data_m_ack,
  input  logic [NUM_IRQ-1:0] intr_in,
  output logic [7:0]         irq,
  output logic               intr,
  input  logic               inta
);

  localparam int IDX_W = $clog2(NUM_IRQ);
  localparam int VEC_W = 8 - IDX_W;

  localparam logic [1:0] ST_ICW1 = 2'd0;
  localparam logic [1:0] ST_ICW2 = 2'd1;
  localparam logic [1:0] ST_ICW4 = 2'd2;
  localparam logic [1:0] ST_IDLE = 2'd3;

  localparam logic [1:0] RD_IRR = 2'b10;
  localparam logic [1:0] RD_ISR = 2'b11;

  logic [1:0]         init_q, init_d;
  logic [NUM_IRQ-1:0] mask_q, mask_d, irr_q, irr_d, isr_q, isr_d, inPrev_q;
  logic [VEC_W-1:0]   vbase_q, vbase_d;
  logic               ltim_q, ltim_d, aeoi_q, aeoi_d, raeoi_q, raeoi_d;
  logic [IDX_W-1:0]   lp_q, lp_d;
  logic [1:0]         rdSel_q, rdSel_d;
  logic               intr_q, intr_d, ack_q;
  logic [7:0]         irq_q, irq_d;
  logic [15:0]        dout_q;

  logic [7:0]         d;
  logic               busWr, busRd, cmdWr, datWr, icw1Wr;
  logic               unusedHighBits;

  assign d              = data_m_data_in[7:0];
  assign unusedHighBits = ^data_m_data_in[15:8];
  assign busWr          = cs & data_m_access & data_m_wr_en;
  assign busRd          = cs & data_m_access & ~data_m_wr_en;
  assign cmdWr          = busWr & ~addr;
  assign datWr          = busWr & addr;
  assign icw1Wr         = cmdWr & d[4];

  // Rank 0 is the line just after lp; a request wins only if it outranks all in-service lines.
  logic               candValid, isrAny;
  logic [IDX_W-1:0]   candIdx, isrTopIdx;
  always_comb begin
    int bestP, bestI, r;
    bestP     = NUM_IRQ;
    bestI     = NUM_IRQ;
    candIdx   = '0;
    isrTopIdx = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      r = (i + NUM_IRQ - 1 - int'(lp_q)) % NUM_IRQ;
      if (irr_q[i] && !mask_q[i] && r < bestP) begin
        bestP   = r;
        candIdx = IDX_W'(i);
      end
      if (isr_q[i] && r < bestI) begin
        bestI     = r;
        isrTopIdx = IDX_W'(i);
      end
    end
    candValid = bestP < bestI;
    isrAny    = bestI < NUM_IRQ;
  end

  logic [IDX_W-1:0]   intaIdx, ocwL;
  logic               intaHit, lValid;
  logic [NUM_IRQ-1:0] edges;
  assign intaIdx = irq_q[IDX_W-1:0];
  assign intaHit = inta & intr_q;
  assign ocwL    = d[IDX_W-1:0];
  assign lValid  = int'(ocwL) < NUM_IRQ;
  assign edges   = intr_in & ~inPrev_q & ~mask_q;

  always_comb begin
    init_d  = init_q;
    mask_d  = mask_q;
    irr_d   = irr_q;
    isr_d   = isr_q;
    vbase_d = vbase_q;
    ltim_d  = ltim_q;
    aeoi_d  = aeoi_q;
    raeoi_d = raeoi_q;
    lp_d    = lp_q;
    rdSel_d = rdSel_q;

    if (ltim_q) begin
      irr_d = intr_in & ~mask_q;
    end else begin
      if (intaHit) irr_d[intaIdx] = 1'b0;
      irr_d = irr_d | edges;
    end

    if (cmdWr && d[4:3] == 2'b00) begin
      case (d[7:5])
        3'b001: if (isrAny) isr_d[isrTopIdx] = 1'b0;
        3'b011: if (lValid) isr_d[ocwL] = 1'b0;
        3'b101: if (isrAny) begin isr_d[isrTopIdx] = 1'b0; lp_d = isrTopIdx; end
        3'b111: if (lValid) begin isr_d[ocwL] = 1'b0; lp_d = ocwL; end
        3'b110: if (lValid) lp_d = ocwL;
        3'b100: raeoi_d = 1'b1;
        3'b000: raeoi_d = 1'b0;
        default: ;
      endcase
    end

    if (cmdWr && d[4:3] == 2'b01 && init_q == ST_IDLE && d[1]) rdSel_d = d[1:0];

    if (datWr) begin
      case (init_q)
        ST_ICW2: begin vbase_d = d[7:IDX_W]; init_d = ST_ICW4; end
        ST_ICW4: begin aeoi_d = d[1]; init_d = ST_IDLE; end
        ST_IDLE: mask_d = d[NUM_IRQ-1:0];
        default: ;
      endcase
    end

    // Acknowledge is applied after EOI so its ISR set wins on the same bit.
    if (intaHit) begin
      if (!aeoi_q)      isr_d[intaIdx] = 1'b1;
      else if (raeoi_q) lp_d = intaIdx;
    end

    if (icw1Wr) begin
      init_d  = ST_ICW2;
      ltim_d  = d[3];
      mask_d  = '0;
      irr_d   = '0;
      isr_d   = '0;
      aeoi_d  = 1'b0;
      raeoi_d = 1'b0;
      lp_d    = IDX_W'(NUM_IRQ - 1);
    end
  end

  assign intr_d = candValid & (init_q == ST_IDLE) & ~inta & ~icw1Wr;
  assign irq_d  = intr_d ? {vbase_q, candIdx} : 8'h00;

  logic [7:0] maskByte, rdByte;
  always_comb begin
    maskByte                = '0;
    maskByte[NUM_IRQ-1:0]   = mask_q;
    rdByte                  = '0;
    if (rdSel_q == RD_IRR)      rdByte[NUM_IRQ-1:0] = irr_q;
    else if (rdSel_q == RD_ISR) rdByte[NUM_IRQ-1:0] = isr_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      init_q   <= ST_ICW1;
      mask_q   <= '0;
      irr_q    <= '0;
      isr_q    <= '0;
      inPrev_q <= '0;
      vbase_q  <= '0;
      ltim_q   <= 1'b0;
      aeoi_q   <= 1'b0;
      raeoi_q  <= 1'b0;
      lp_q     <= IDX_W'(NUM_IRQ - 1);
      rdSel_q  <= 2'b00;
      intr_q   <= 1'b0;
      irq_q    <= 8'h00;
      ack_q    <= 1'b0;
      dout_q   <= 16'h0000;
    end else begin
      init_q   <= init_d;
      mask_q   <= mask_d;
      irr_q    <= irr_d;
      isr_q    <= isr_d;
      inPrev_q <= intr_in;
      vbase_q  <= vbase_d;
      ltim_q   <= ltim_d;
      aeoi_q   <= aeoi_d;
      raeoi_q  <= raeoi_d;
      lp_q     <= lp_d;
      rdSel_q  <= rdSel_d;
      intr_q   <= intr_d;
      irq_q    <= irq_d;
      ack_q    <= cs & data_m_access;
      dout_q   <= busRd ? {maskByte, rdByte} : 16'h0000;
    end
  end

  assign intr            = intr_q;
  assign irq             = irq_q;
  assign data_m_ack      = ack_q;
  assign data_m_data_out = dout_q;

endmodule

// File: tb/tb_pic_multimode.sv
// Directed bench for pic_multimode: a priority vector table on an 8-line
// instance plus hand-written nesting, level, AEOI and 4-line sequences.
module tb_pic_multimode;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cs = 1'b0, addr = 1'b0, wrEn = 1'b0, access = 1'b0, inta = 1'b0;
  logic [15:0] dIn = 16'h0;
  logic [7:0]  lines8 = 8'h0;
  logic [3:0]  lines4 = 4'h0;
  logic [15:0] dout8, dout4;
  logic        ack8, ack4, intr8, intr4;
  logic [7:0]  irq8, irq4;

  int checks = 0;
  int errors = 0;
  logic [15:0] rd8, rd4;

  always #5 clk = ~clk;

  pic_multimode #(.NUM_IRQ(8)) dut8 (
    .clk(clk), .reset(reset), .cs(cs), .addr(addr), .data_m_data_in(dIn),
    .data_m_data_out(dout8), .data_m_wr_en(wrEn), .data_m_access(access),
    .data_m_ack(ack8), .intr_in(lines8), .irq(irq8), .intr(intr8), .inta(inta)
  );

  pic_multimode #(.NUM_IRQ(4)) dut4 (
    .clk(clk), .reset(reset), .cs(cs), .addr(addr), .data_m_data_in(dIn),
    .data_m_data_out(dout4), .data_m_wr_en(wrEn), .data_m_access(access),
    .data_m_ack(ack4), .intr_in(lines4), .irq(irq4), .intr(intr4), .inta(inta)
  );

  typedef struct {
    logic [7:0] ocw2;
    logic [7:0] mask;
    logic [7:0] lines;
    logic       expIntr;
    logic [7:0] expIrq;
  } vec_t;

  vec_t vecs[11];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
    end
  endtask

  task automatic busWrite(input logic a, input logic [7:0] v);
    cs = 1'b1; access = 1'b1; wrEn = 1'b1; addr = a; dIn = {8'h00, v};
    tick();
    cs = 1'b0; access = 1'b0; wrEn = 1'b0;
  endtask

  task automatic busRead();
    cs = 1'b1; access = 1'b1; wrEn = 1'b0; addr = 1'b1;
    tick();
    rd8 = dout8;
    rd4 = dout4;
    cs = 1'b0; access = 1'b0;
  endtask

  task automatic pulseInta();
    inta = 1'b1;
    tick();
    inta = 1'b0;
  endtask

  task automatic waitIntr(input int which, input string name);
    for (int n = 0; n < 12; n++) begin
      if ((which == 8 && intr8) || (which == 4 && intr4)) break;
      tick();
    end
    checkOutput(name, {15'h0, (which == 8) ? intr8 : intr4}, 16'h0001);
  endtask

  task automatic initPic(input logic [7:0] icw1, input logic [7:0] icw2, input logic [7:0] icw4);
    busWrite(1'b0, icw1);
    busWrite(1'b1, icw2);
    busWrite(1'b1, icw4);
    busWrite(1'b1, 8'h00);
  endtask

  task automatic applyStimulus(input vec_t v);
    lines8 = 8'h00;
    tick();
    initPic(8'h11, 8'h08, 8'h00);
    busWrite(1'b1, v.mask);
    busWrite(1'b0, v.ocw2);
    lines8 = v.lines;
    repeat (4) tick();
  endtask

  initial begin
    vecs[0]  = '{8'h40, 8'h00, 8'h08, 1'b1, 8'h0B};
    vecs[1]  = '{8'h40, 8'h00, 8'h28, 1'b1, 8'h0B};
    vecs[2]  = '{8'h40, 8'h00, 8'hFF, 1'b1, 8'h08};
    vecs[3]  = '{8'hC4, 8'h00, 8'h44, 1'b1, 8'h0E};
    vecs[4]  = '{8'hC7, 8'h00, 8'h44, 1'b1, 8'h0A};
    vecs[5]  = '{8'hC0, 8'h00, 8'h81, 1'b1, 8'h0F};
    vecs[6]  = '{8'h40, 8'h08, 8'h08, 1'b0, 8'h00};
    vecs[7]  = '{8'h40, 8'h01, 8'h03, 1'b1, 8'h09};
    vecs[8]  = '{8'hC2, 8'h00, 8'h05, 1'b1, 8'h08};
    vecs[9]  = '{8'h40, 8'h00, 8'h00, 1'b0, 8'h00};
    vecs[10] = '{8'hC0, 8'h00, 8'h03, 1'b1, 8'h09};

    repeat (2) tick();
    checkOutput("reset_intr", {15'h0, intr8}, 16'h0);
    checkOutput("reset_irq", {8'h0, irq8}, 16'h0);
    checkOutput("reset_ack", {15'h0, ack8}, 16'h0);
    checkOutput("reset_dout", dout8, 16'h0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d_intr", i), {15'h0, intr8}, {15'h0, vecs[i].expIntr});
      checkOutput($sformatf("vec%0d_irq", i), {8'h0, irq8}, {8'h0, vecs[i].expIrq});
    end

    // Basic edge request, acknowledge and in-service readback
    lines8 = 8'h00;
    tick();
    initPic(8'h11, 8'h08, 8'h00);
    lines8 = 8'h08;
    waitIntr(8, "t1_intr");
    checkOutput("t1_irq", {8'h0, irq8}, 16'h000B);
    lines8 = 8'h00;
    pulseInta();
    checkOutput("t1_intr_drop", {15'h0, intr8}, 16'h0);
    busWrite(1'b0, 8'h0B);
    busRead();
    checkOutput("t1_isr", rd8, 16'h0008);

    // Nesting: lower priority blocked, higher priority preempts, non-specific EOI
    lines8 = 8'h20;
    repeat (4) tick();
    checkOutput("t2_irq5_blocked", {15'h0, intr8}, 16'h0);
    lines8 = 8'h22;
    waitIntr(8, "t2_intr");
    checkOutput("t2_irq_nested", {8'h0, irq8}, 16'h0009);
    pulseInta();
    busRead();
    checkOutput("t2_isr_both", rd8, 16'h000A);
    busWrite(1'b0, 8'h20);
    busRead();
    checkOutput("t2_isr_after_eoi", rd8, 16'h0008);
    repeat (2) tick();
    checkOutput("t2_still_blocked", {15'h0, intr8}, 16'h0);
    busWrite(1'b0, 8'h20);
    waitIntr(8, "t2_intr5");
    checkOutput("t2_irq5", {8'h0, irq8}, 16'h000D);

    // ICW1 drops intr immediately; then specific rotation to lp=4
    lines8 = 8'h00;
    tick();
    busWrite(1'b0, 8'h11);
    checkOutput("t3_icw1_intr", {15'h0, intr8}, 16'h0);
    busWrite(1'b1, 8'h08);
    busWrite(1'b1, 8'h00);
    busWrite(1'b1, 8'h00);
    busWrite(1'b0, 8'hC4);
    lines8 = 8'h44;
    waitIntr(8, "t3_intr");
    checkOutput("t3_irq6", {8'h0, irq8}, 16'h000E);
    pulseInta();
    repeat (2) tick();
    checkOutput("t3_irq2_blocked", {15'h0, intr8}, 16'h0);
    busWrite(1'b0, 8'h20);
    waitIntr(8, "t3_intr2");
    checkOutput("t3_irq2", {8'h0, irq8}, 16'h000A);

    // Level mode: request withdrawn before acknowledge
    lines8 = 8'h00;
    tick();
    initPic(8'h19, 8'h08, 8'h00);
    lines8 = 8'h10;
    waitIntr(8, "t4_intr");
    checkOutput("t4_irq", {8'h0, irq8}, 16'h000C);
    lines8 = 8'h00;
    repeat (2) tick();
    checkOutput("t4_intr_gone", {15'h0, intr8}, 16'h0);
    busWrite(1'b0, 8'h0A);
    busRead();
    checkOutput("t4_irr", rd8, 16'h0000);
    pulseInta();
    busWrite(1'b0, 8'h0B);
    busRead();
    checkOutput("t4_stray_inta", rd8, 16'h0000);

    // Auto-EOI with rotation: serviced IRQ0 becomes lowest priority
    initPic(8'h11, 8'h08, 8'h02);
    busWrite(1'b0, 8'h80);
    lines8 = 8'h01;
    waitIntr(8, "t5_intr");
    checkOutput("t5_irq0", {8'h0, irq8}, 16'h0008);
    pulseInta();
    lines8 = 8'h00;
    busWrite(1'b0, 8'h0B);
    busRead();
    checkOutput("t5_isr_clear", rd8, 16'h0000);
    lines8 = 8'h03;
    waitIntr(8, "t5_intr2");
    checkOutput("t5_irq1", {8'h0, irq8}, 16'h0009);

    // Four-line instance: vector base, IRR readback, asynchronous reset
    lines8 = 8'h00;
    tick();
    initPic(8'h11, 8'h20, 8'h00);
    lines4 = 4'h8;
    waitIntr(4, "t6_intr");
    checkOutput("t6_irq3", {8'h0, irq4}, 16'h0023);
    pulseInta();
    lines4 = 4'hC;
    waitIntr(4, "t6_intr2");
    checkOutput("t6_irq2", {8'h0, irq4}, 16'h0022);
    busWrite(1'b0, 8'h0A);
    busRead();
    checkOutput("t6_irr", rd4, 16'h0004);
    cs = 1'b1; access = 1'b1; wrEn = 1'b0;
    tick();
    checkOutput("t6_ack", {15'h0, ack4}, 16'h0001);
    reset = 1'b1;
    #1;
    checkOutput("t6_rst_dout", dout4, 16'h0);
    checkOutput("t6_rst_ack", {15'h0, ack4}, 16'h0);
    checkOutput("t6_rst_intr", {15'h0, intr4}, 16'h0);
    checkOutput("t6_rst_irq", {8'h0, irq4}, 16'h0);
    cs = 1'b0; access = 1'b0;
    tick();
    reset = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
